// File: rtl/regfile_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile_pkg: shared register-file constants for the writeback path. Rev 1.0
// ----------------------------------------------------------------------------
package regfile_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int NUM_REGS     = 32;
  localparam int DEFAULT_XLEN = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Index width that stays legal for single-entry vectors.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arbiter: combinational round-robin grant with a registered priority pointer. Rev 1.0
// ----------------------------------------------------------------------------
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IDX_W  = idx_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] ptr;
  int               cand;
  logic             found;

  // Scan starting at ptr, wrapping; the first valid requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && !rst && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile_wb_arbiter: shares the register-file write port among writeback units
// and tracks pending writes for RAW stalls. Rev 1.0
// ----------------------------------------------------------------------------
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = DEFAULT_XLEN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*XLEN-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rf_wr_en,
  output logic [REG_ADDR_W-1:0]      rf_rd,
  output logic [XLEN-1:0]            rf_wdata,
  input  logic                       issue_valid,
  input  logic [REG_ADDR_W-1:0]      issue_rd,
  output logic [NUM_REGS-1:0]        busy
);

  localparam int IDX_W = idx_width(NUM_REQ);

  logic [IDX_W-1:0]      gnt_idx;
  logic                  xfer;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]       sel_wdata;
  logic [NUM_REGS-1:0]   busy_next;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .grant     (req_ready),
    .grant_idx (gnt_idx)
  );

  assign xfer      = |req_ready;
  assign sel_rd    = req_rd[int'(gnt_idx)*REG_ADDR_W +: REG_ADDR_W];
  assign sel_wdata = req_wdata[int'(gnt_idx)*XLEN +: XLEN];

  // Address and data hold between writes; only the enable pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wr_en <= 1'b0;
      rf_rd    <= REG_ZERO;
      rf_wdata <= '0;
    end else if (xfer) begin
      rf_wr_en <= (sel_rd != REG_ZERO);
      rf_rd    <= sel_rd;
      rf_wdata <= sel_wdata;
    end else begin
      rf_wr_en <= 1'b0;
    end
  end

  // Set applied after clear so a freshly issued producer keeps the bit.
  always_comb begin
    busy_next = busy;
    if (rf_wr_en) busy_next[rf_rd] = 1'b0;
    if (issue_valid && issue_rd != REG_ZERO) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_regfile_wb_arbiter: directed self-checking bench for regfile_wb_arbiter. Rev 1.0
// ----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [9:0]  req_rd;
  logic [63:0] req_wdata;
  logic [1:0]  req_ready;
  logic        rf_wr_en;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [31:0] busy;

  int total = 0;
  int bad   = 0;

  logic [31:0] regs [32];
  logic [1:0]  pend;

  regfile_wb_arbiter #(.NUM_REQ(2), .XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_rd      (req_rd),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rf_wr_en    (rf_wr_en),
    .rf_rd       (rf_rd),
    .rf_wdata    (rf_wdata),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial for (int r = 0; r < 32; r++) regs[r] = '0;

  // Register file model: stores on the edge where the write stage is enabled.
  always @(posedge clk) begin
    if (rf_wr_en && rf_rd != 5'd0) regs[rf_rd] <= rf_wdata;
  end

  // Protocol monitors: held requests and double issue to a busy register.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst && pend[i]) assert (req_valid[i]) else check("valid_held", 64'(req_valid[i]), 64'd1);
    end
    if (!rst && issue_valid && issue_rd != 5'd0 && !(rf_wr_en && rf_rd == issue_rd))
      assert (!busy[issue_rd]) else check("issue_busy", 64'(busy[issue_rd]), 64'd0);
    pend <= rst ? 2'b00 : (req_valid & ~req_ready);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_req(input logic [1:0] v, input logic [4:0] rd0, input logic [31:0] wd0,
                         input logic [4:0] rd1, input logic [31:0] wd1);
    req_valid = v;
    req_rd    = {rd1, rd0};
    req_wdata = {wd1, wd0};
  endtask

  initial begin
    pend        = 2'b00;
    rst         = 1'b1;
    issue_valid = 1'b0;
    issue_rd    = 5'd0;
    set_req(2'b11, 5'd5, 32'hAAAA0000, 5'd6, 32'hBBBB0000);
    #1;
    check("rst_ready0", 64'(req_ready), 64'h0);

    step(); #1;
    check("rst_ready1", 64'(req_ready), 64'h0);
    check("rst_wr_en",  64'(rf_wr_en),  64'h0);
    check("rst_rd",     64'(rf_rd),     64'h0);
    check("rst_wdata",  64'(rf_wdata),  64'h0);
    check("rst_busy",   64'(busy),      64'h0);

    // Contention: grants alternate starting from requester 0.
    step(); rst = 1'b0; #1;
    check("c0_ready", 64'(req_ready), 64'h1);
    check("c0_wr_en", 64'(rf_wr_en),  64'h0);
    step(); #1;
    check("c1_ready", 64'(req_ready), 64'h2);
    check("c1_wr",    {31'd0, rf_wr_en, 27'd0, rf_rd}, {31'd0, 1'b1, 27'd0, 5'd5});
    check("c1_wdata", 64'(rf_wdata), 64'hAAAA0000);
    step(); #1;
    check("c2_ready", 64'(req_ready), 64'h1);
    check("c2_wr",    {31'd0, rf_wr_en, 27'd0, rf_rd}, {31'd0, 1'b1, 27'd0, 5'd6});
    check("c2_wdata", 64'(rf_wdata), 64'hBBBB0000);
    step(); req_valid = 2'b10; #1;
    check("c3_ready", 64'(req_ready), 64'h2);
    check("c3_wr",    {31'd0, rf_wr_en, 27'd0, rf_rd}, {31'd0, 1'b1, 27'd0, 5'd5});
    step(); req_valid = 2'b00; #1;
    check("c4_ready", 64'(req_ready), 64'h0);
    check("c4_wr",    {31'd0, rf_wr_en, 27'd0, rf_rd}, {31'd0, 1'b1, 27'd0, 5'd6});
    step(); #1;
    check("idle_wr_en", 64'(rf_wr_en), 64'h0);
    check("idle_rd",    64'(rf_rd),    64'd6);
    check("idle_wdata", 64'(rf_wdata), 64'hBBBB0000);
    check("c_regs5",    64'(regs[5]),  64'hAAAA0000);
    check("c_regs6",    64'(regs[6]),  64'hBBBB0000);

    // rd=0 is accepted but never writes.
    step(); set_req(2'b01, 5'd0, 32'hDEADBEEF, 5'd0, 32'h0); #1;
    check("z_ready", 64'(req_ready), 64'h1);
    step(); req_valid = 2'b00; #1;
    check("z_wr_en", 64'(rf_wr_en), 64'h0);
    check("z_wdata", 64'(rf_wdata), 64'hDEADBEEF);
    check("z_busy0", 64'(busy[0]),  64'h0);

    // Scoreboard set then clear on commit.
    step(); issue_valid = 1'b1; issue_rd = 5'd7; #1;
    step(); issue_valid = 1'b0;
    set_req(2'b10, 5'd0, 32'h0, 5'd7, 32'h12345678); #1;
    check("sb_busy_set", 64'(busy), 64'h80);
    check("sb_ready",    64'(req_ready), 64'h2);
    step(); req_valid = 2'b00; #1;
    check("sb_wr",      {31'd0, rf_wr_en, 27'd0, rf_rd}, {31'd0, 1'b1, 27'd0, 5'd7});
    check("sb_busy_hold", 64'(busy), 64'h80);
    step(); #1;
    check("sb_busy_clr", 64'(busy),    64'h0);
    check("sb_regs7",    64'(regs[7]), 64'h12345678);

    // Commit and reissue of rd=9 on the same edge keeps it busy.
    step(); issue_valid = 1'b1; issue_rd = 5'd9;
    set_req(2'b01, 5'd9, 32'h00000055, 5'd0, 32'h0); #1;
    check("col_ready", 64'(req_ready), 64'h1);
    step(); req_valid = 2'b00; #1;
    check("col_wr",   {31'd0, rf_wr_en, 27'd0, rf_rd}, {31'd0, 1'b1, 27'd0, 5'd9});
    check("col_busy0", 64'(busy), 64'h200);
    step(); issue_valid = 1'b0; #1;
    check("col_busy1",  64'(busy),     64'h200);
    check("col_wr_en",  64'(rf_wr_en), 64'h0);
    check("col_regs9",  64'(regs[9]),  64'h55);

    // Reset the cycle after a transfer to rd=3.
    step(); issue_valid = 1'b1; issue_rd = 5'd3;
    set_req(2'b10, 5'd0, 32'h0, 5'd3, 32'h00000033); #1;
    check("mr_ready", 64'(req_ready), 64'h2);
    step(); issue_valid = 1'b0; req_valid = 2'b00; rst = 1'b1; #1;
    check("mr_pre_wr", {31'd0, rf_wr_en, 27'd0, rf_rd}, {31'd0, 1'b1, 27'd0, 5'd3});
    check("mr_pre_busy", 64'(busy), 64'h208);
    check("mr_rst_ready", 64'(req_ready), 64'h0);
    step(); rst = 1'b0;
    set_req(2'b11, 5'd4, 32'h00000044, 5'd3, 32'h00000033); #1;
    check("mr_wr_en", 64'(rf_wr_en), 64'h0);
    check("mr_busy",  64'(busy),     64'h0);
    check("mr_ptr0",  64'(req_ready), 64'h1);
    step(); req_valid = 2'b10; #1;
    check("mr_ready1", 64'(req_ready), 64'h2);
    check("mr_wr4",   {31'd0, rf_wr_en, 27'd0, rf_rd}, {31'd0, 1'b1, 27'd0, 5'd4});
    check("mr_wd4",   64'(rf_wdata), 64'h44);
    step(); req_valid = 2'b00; #1;
    check("mr_wr3",   {31'd0, rf_wr_en, 27'd0, rf_rd}, {31'd0, 1'b1, 27'd0, 5'd3});
    check("mr_wd3",   64'(rf_wdata), 64'h33);

    step(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
